// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT unsigned products over valid/ready handshakes with a sticky overflow flag
module product_accumulator #(
  parameter int IN_WIDTH = 4,
  parameter int PROD_WIDTH = 2 * IN_WIDTH,
  parameter int COUNT = 4,
  parameter int ACC_WIDTH = PROD_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  overflow,
  output logic                  busy
);
  localparam int EXT_WIDTH = ACC_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, ACC, DONE} stateT;
  stateT state;
  logic [7:0] cnt;
  logic [ACC_WIDTH:0] nextSum;
  // one extra bit captures the carry out of the accumulator
  assign nextSum = {1'b0, sum} + EXT_WIDTH'(product);
  assign in_ready = state == ACC;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sum <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sum <= '0;
          cnt <= '0;
          overflow <= 1'b0;
          state <= ACC;
        end
        ACC: if (in_valid) begin
          sum <= nextSum[ACC_WIDTH-1:0];
          overflow <= overflow | nextSum[ACC_WIDTH];
          cnt <= cnt + 8'd1;
          if (cnt + 8'd1 == 8'(COUNT)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
